// File: rtl/copy_read_dispatcher.sv
// copy_read_dispatcher: splits a copy command into per-line ram block reads and re-injects retried tokens
module copy_read_dispatcher #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_des_addr,
  input  logic [ADDR_W-1:0]   cmd_offset,
  input  logic [LEN_W-1:0]    cmd_length,
  input  logic                retry_valid,
  output logic                retry_ready,
  input  logic [3:0]          retry_block,
  input  logic [ADDR_W+16:0]  retry_token,
  output logic [15:0]         rd_valid,
  output logic [ADDR_W-8:0]   rd_address,
  output logic [7:0]          rd_mask,
  output logic [ADDR_W-1:0]   rd_offset,
  output logic                busy
);
  localparam int LINE_W = ADDR_W - 3;
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t              state;
  logic [LINE_W-1:0]   cur_line, last_line;
  logic [2:0]          first_byte, last_byte;
  logic [ADDR_W-1:0]   offset;
  logic                first;
  logic [ADDR_W-1:0]   src_addr, end_addr;
  logic [2:0]          lo, hi;
  logic [7:0]          split_mask;
  logic                cmd_take;
  assign cmd_ready   = (state == IDLE) & ~flush;
  assign retry_ready = ~flush;
  assign busy        = state != IDLE;
  assign src_addr    = cmd_des_addr - cmd_offset;
  assign end_addr    = src_addr + {{(ADDR_W-LEN_W){1'b0}}, cmd_length} - ADDR_W'(1);
  assign cmd_take    = cmd_valid & cmd_ready & (cmd_length != '0) & (cmd_offset != '0);
  assign lo          = first ? first_byte : 3'd0;
  assign hi          = (cur_line == last_line) ? last_byte : 3'd7;
  // byte k of a line sits at mask bit 7-k, so lo clears the top bits and hi the bottom ones
  assign split_mask  = (8'hFF >> lo) & (8'hFF << (3'd7 - hi));
  // issue slot: retries beat new splits; a dropped zero-length/zero-offset command never leaves IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_line   <= '0;
      last_line  <= '0;
      first_byte <= '0;
      last_byte  <= '0;
      offset     <= '0;
      first      <= 1'b0;
      rd_valid   <= '0;
      rd_address <= '0;
      rd_mask    <= '0;
      rd_offset  <= '0;
    end else if (flush) begin
      state    <= IDLE;
      rd_valid <= '0;
    end else begin
      rd_valid <= '0;
      if (retry_valid) begin
        rd_valid   <= 16'd1 << retry_block;
        rd_address <= retry_token[ADDR_W+16:ADDR_W+8];
        rd_mask    <= retry_token[ADDR_W+7:ADDR_W];
        rd_offset  <= retry_token[ADDR_W-1:0];
      end else if (state == SPLIT) begin
        rd_valid   <= 16'd1 << cur_line[3:0];
        rd_address <= cur_line[LINE_W-1:4];
        rd_mask    <= split_mask;
        rd_offset  <= offset;
        first      <= 1'b0;
        cur_line   <= cur_line + LINE_W'(1);
        state      <= (cur_line == last_line) ? IDLE : SPLIT;
      end
      if (cmd_take) begin
        cur_line   <= src_addr[ADDR_W-1:3];
        last_line  <= end_addr[ADDR_W-1:3];
        first_byte <= src_addr[2:0];
        last_byte  <= end_addr[2:0];
        offset     <= cmd_offset;
        first      <= 1'b1;
        state      <= SPLIT;
      end
    end
  end
endmodule

// File: tb/tb_copy_read_dispatcher.sv
// tb_copy_read_dispatcher: directed checks of line splitting, retry priority, flush and dropped commands
module tb_copy_read_dispatcher;
  logic        clk = 1'b0;
  logic        rst_n, flush, cmd_valid, cmd_ready, retry_valid, retry_ready, busy;
  logic [15:0] cmd_des_addr, cmd_offset, rd_valid, rd_offset;
  logic [6:0]  cmd_length;
  logic [3:0]  retry_block;
  logic [32:0] retry_token;
  logic [8:0]  rd_address;
  logic [7:0]  rd_mask;
  int          total = 0;
  int          bad = 0;

  copy_read_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_des_addr(cmd_des_addr), .cmd_offset(cmd_offset), .cmd_length(cmd_length),
    .retry_valid(retry_valid), .retry_ready(retry_ready),
    .retry_block(retry_block), .retry_token(retry_token),
    .rd_valid(rd_valid), .rd_address(rd_address), .rd_mask(rd_mask),
    .rd_offset(rd_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [15:0] v, input logic [8:0] a,
                        input logic [7:0] m, input logic [15:0] o);
    chk({tag, ".valid"}, 32'(rd_valid), 32'(v));
    chk({tag, ".addr"}, 32'(rd_address), 32'(a));
    chk({tag, ".mask"}, 32'(rd_mask), 32'(m));
    chk({tag, ".off"}, 32'(rd_offset), 32'(o));
  endtask

  task automatic send(input logic [15:0] des, input logic [15:0] off, input logic [6:0] len);
    cmd_valid = 1'b1; cmd_des_addr = des; cmd_offset = off; cmd_length = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; cmd_valid = 1'b0; retry_valid = 1'b0;
    cmd_des_addr = '0; cmd_offset = '0; cmd_length = '0; retry_block = '0; retry_token = '0;
    tick(); tick();
    chk_rd("reset", 16'h0, 9'h0, 8'h0, 16'h0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.cmd_ready", 32'(cmd_ready), 32'd1);
    chk("idle.retry_ready", 32'(retry_ready), 32'd1);
    // single aligned line
    send(16'h0010, 16'd8, 7'd8);
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    chk_rd("t1.r1", 16'h0002, 9'h0, 8'hFF, 16'd8);
    chk("t1.done_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("t1.quiet", 32'(rd_valid), 32'd0);
    // two partial lines
    send(16'h0105, 16'd3, 7'd10);
    chk("t2.cmd_ready0", 32'(cmd_ready), 32'd0);
    tick();
    chk_rd("t2.r1", 16'h0001, 9'h2, 8'h3F, 16'd3);
    chk("t2.cmd_ready1", 32'(cmd_ready), 32'd0);
    tick();
    chk_rd("t2.r2", 16'h0002, 9'h2, 8'hF0, 16'd3);
    chk("t2.cmd_ready2", 32'(cmd_ready), 32'd1);
    // source wraps below address 0
    send(16'h0002, 16'd4, 7'd4);
    tick();
    chk_rd("t3.r1", 16'h8000, 9'h1FF, 8'h03, 16'd4);
    tick();
    chk_rd("t3.r2", 16'h0001, 9'h0, 8'hC0, 16'd4);
    chk("t3.busy", 32'(busy), 32'd0);
    // nine lines from src 0x0007, retry on split cycle 3
    send(16'h0100, 16'h00F9, 7'd64);
    tick();
    chk_rd("t4.l0", 16'h0001, 9'h0, 8'h01, 16'h00F9);
    tick();
    chk_rd("t4.l1", 16'h0002, 9'h0, 8'hFF, 16'h00F9);
    retry_valid = 1'b1; retry_block = 4'd5; retry_token = {9'h0A3, 8'h0C, 16'h0004};
    tick();
    retry_valid = 1'b0;
    chk_rd("t4.retry", 16'h0020, 9'h0A3, 8'h0C, 16'h0004);
    chk("t4.busy", 32'(busy), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_rd($sformatf("t4.l%0d", i), 16'd1 << i, 9'h0, (i == 8) ? 8'hFE : 8'hFF, 16'h00F9);
    end
    chk("t4.end_busy", 32'(busy), 32'd0);
    tick();
    chk("t4.quiet", 32'(rd_valid), 32'd0);
    // flush on split cycle 2, then a fresh command
    send(16'h0100, 16'h00F9, 7'd64);
    tick();
    chk_rd("t5.l0", 16'h0001, 9'h0, 8'h01, 16'h00F9);
    flush = 1'b1; retry_valid = 1'b1;
    #1;
    chk("t5.flush_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t5.flush_retry_ready", 32'(retry_ready), 32'd0);
    tick();
    flush = 1'b0; retry_valid = 1'b0;
    chk("t5.rd_valid", 32'(rd_valid), 32'd0);
    chk("t5.busy", 32'(busy), 32'd0);
    tick();
    chk("t5.still_quiet", 32'(rd_valid), 32'd0);
    send(16'h0105, 16'd3, 7'd10);
    tick();
    chk_rd("t5.n1", 16'h0001, 9'h2, 8'h3F, 16'd3);
    tick();
    chk_rd("t5.n2", 16'h0002, 9'h2, 8'hF0, 16'd3);
    // dropped commands
    chk("t6.ready", 32'(cmd_ready), 32'd1);
    send(16'h0040, 16'd8, 7'd0);
    chk("t6.len0_busy", 32'(busy), 32'd0);
    chk("t6.len0_valid", 32'(rd_valid), 32'd0);
    tick();
    chk("t6.len0_valid2", 32'(rd_valid), 32'd0);
    send(16'h0040, 16'd0, 7'd8);
    chk("t6.off0_busy", 32'(busy), 32'd0);
    tick();
    chk("t6.off0_valid", 32'(rd_valid), 32'd0);
    // retry and command together in IDLE
    retry_valid = 1'b1; retry_block = 4'd9; retry_token = {9'h155, 8'hA5, 16'h1234};
    send(16'h0010, 16'd8, 7'd8);
    retry_valid = 1'b0;
    chk_rd("t7.retry", 16'h0200, 9'h155, 8'hA5, 16'h1234);
    chk("t7.busy", 32'(busy), 32'd1);
    tick();
    chk_rd("t7.split", 16'h0002, 9'h0, 8'hFF, 16'd8);
    chk("t7.idle", 32'(busy), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
